// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with word-serial block fill, whole-cache flush
// and saturating hit/miss counters. Lookup is combinational; storage is all flops.
module icache_dm_param #(
  parameter int SETS     = 16,
  parameter int BLKWORDS = 2,
  parameter int CNTW     = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  input  logic            flush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);

  localparam int W  = $clog2(BLKWORDS);
  localparam int I  = $clog2(SETS);
  localparam int TW = 30 - W - I;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  localparam logic [W-1:0] LAST_WORD = W'(BLKWORDS - 1);

  logic [0:0]      state_q, state_d;
  logic [TW-1:0]   fill_tag_q, fill_tag_d;
  logic [I-1:0]    fill_idx_q, fill_idx_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS-1:0];
  logic [31:0]     data_q [SETS-1:0][BLKWORDS-1:0];

  logic [W-1:0]  req_off;
  logic [I-1:0]  req_idx;
  logic [TW-1:0] req_tag;
  logic          tag_match;
  logic          miss;
  logic          xfer;
  logic          addr_lsb_unused;

  assign req_off         = imemaddr[2+W-1:2];
  assign req_idx         = imemaddr[2+W+I-1:2+W];
  assign req_tag         = imemaddr[31:2+W+I];
  assign addr_lsb_unused = ^imemaddr[1:0];

  assign tag_match = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign ihit      = (state_q == IDLE) && imemREN && tag_match && !flush;
  assign miss      = (state_q == IDLE) && imemREN && !tag_match && !flush;
  // Flush outranks a word arriving in the same cycle: the aborted line is dropped.
  assign xfer      = (state_q == FILL) && !iwait && !flush;

  assign imemload   = data_q[req_idx][req_off];
  assign iREN       = (state_q == FILL);
  assign iaddr      = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else if (miss) begin
      state_d    = FILL;
      fill_tag_d = req_tag;
      fill_idx_d = req_idx;
      cnt_d      = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + W'(1);
      if (cnt_q == LAST_WORD) state_d = IDLE;
    end

    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (ihit && !(&hit_cnt_q))  hit_cnt_d  = hit_cnt_q + CNTW'(1);
    if (miss && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNTW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line storage: the tag and valid bit are committed only with the final word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s] <= '0;
        for (int w = 0; w < BLKWORDS; w++) data_q[s][w] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (xfer) begin
      data_q[fill_idx_q][cnt_q] <= iload;
      if (cnt_q == LAST_WORD) begin
        valid_q[fill_idx_q] <= 1'b1;
        tag_q[fill_idx_q]   <= fill_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm_param.sv
// Scoreboard bench for icache_dm_param: 16 sets, 2-word blocks, memory with 2 wait
// cycles per word; a second instance with 4-bit counters checks saturation.
module tb_icache_dm_param;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        flush = 1'b0;
  logic        iwait;
  logic [31:0] iload;

  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  logic [31:0] hit_count, miss_count;

  logic        ihit_s, iREN_s;
  logic [31:0] imemload_s, iaddr_s;
  logic [3:0]  hit_count_s, miss_count_s;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int iren_cycles = 0;
  int wcnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] fetch_q[$];

  always #5 CLK = ~CLK;

  icache_dm_param #(.SETS(16), .BLKWORDS(2), .CNTW(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_dm_param #(.SETS(16), .BLKWORDS(2), .CNTW(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit_s), .imemload(imemload_s), .flush(flush), .iREN(iREN_s),
    .iaddr(iaddr_s), .iwait(iwait), .iload(iload),
    .hit_count(hit_count_s), .miss_count(miss_count_s)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ 16'h5A3C};
  endfunction

  // Memory: two wait cycles, then one transfer cycle, per word.
  assign iwait = !(iREN && wcnt == 2);
  assign iload = memval(iaddr);

  always @(posedge CLK) begin
    if (!iREN)          wcnt <= 0;
    else if (wcnt == 2) wcnt <= 0;
    else                wcnt <= wcnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fetch monitor: every word transfer must match the next expected fill address.
  always @(negedge CLK) begin
    #2;
    if (iREN) iren_cycles++;
    if (iREN && !iwait) begin
      if (fetch_q.size() == 0) check_val("fetch_extra", fetch_q.size(), 1);
      else                     check_val("fetch_addr", iaddr, fetch_q.pop_front());
    end
  end

  task automatic access(input logic [31:0] a, input bit is_miss, input int hold);
    int cyc;
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    exp_q.push_back(memval({a[31:2], 2'b00}));
    if (is_miss) begin
      fetch_q.push_back(base);
      fetch_q.push_back(base + 32'd4);
      exp_misses++;
    end
    imemREN = 1'b1;
    imemaddr = a;
    iren_cycles = 0;
    cyc = 0;
    #1;
    while (!ihit && cyc < 40) begin
      @(negedge CLK); #1;
      cyc++;
    end
    check_val("ihit_seen", 32'(ihit), 32'd1);
    check_val("latency", cyc, is_miss ? 7 : 0);
    check_val("iren_cycles", iren_cycles, is_miss ? 6 : 0);
    check_val("imemload", imemload, exp_q.pop_front());
    check_val("miss_count", miss_count, exp_misses);
    repeat (hold) @(negedge CLK);
    exp_hits += hold;
    #1;
    check_val("hit_count", hit_count, exp_hits);
    check_val("hit_count_sat", 32'(hit_count_s), (exp_hits > 15) ? 15 : exp_hits);
    $display("access addr=%h miss=%0d latency=%0d data=%h hits=%0d misses=%0d",
             a, is_miss, cyc, imemload, hit_count, miss_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_val("rst_ihit", 32'(ihit), 32'd0);
    check_val("rst_imemload", imemload, 32'd0);
    check_val("rst_iren", 32'(iREN), 32'd0);
    check_val("rst_iaddr", iaddr, 32'd0);
    check_val("rst_hit_count", hit_count, 32'd0);
    check_val("rst_miss_count", miss_count, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK); #1;

    // Cold miss, then a hit held long enough to saturate the 4-bit counter.
    access(32'h0000_0000, 1'b1, 1);
    access(32'h0000_0004, 1'b0, 20);

    // Conflict on index 0: tag 1 evicts tag 0, which then misses again.
    access(32'h0000_0080, 1'b1, 1);
    access(32'h0000_0000, 1'b1, 1);
    check_val("miss_count_conflict", miss_count, 32'd3);
    access(32'h0000_0004, 1'b0, 1);

    // Flush while idle on a hitting address.
    flush = 1'b1;
    #1;
    check_val("flush_idle_ihit", 32'(ihit), 32'd0);
    @(negedge CLK); #1;
    flush = 1'b0;
    check_val("flush_idle_iren", 32'(iREN), 32'd0);
    check_val("flush_idle_miss", miss_count, exp_misses);
    check_val("flush_idle_hits", hit_count, exp_hits);
    access(32'h0000_0004, 1'b1, 1);

    // Flush during the second word's wait aborts the fill.
    imemREN = 1'b1;
    imemaddr = 32'h0000_0100;
    fetch_q.push_back(32'h0000_0100);
    exp_misses++;
    repeat (4) @(negedge CLK);
    #1;
    check_val("fill_word1_wait", 32'(iREN), 32'd1);
    flush = 1'b1;
    @(negedge CLK); #1;
    flush = 1'b0;
    check_val("flush_fill_iren", 32'(iREN), 32'd0);
    check_val("flush_fill_ihit", 32'(ihit), 32'd0);
    access(32'h0000_0100, 1'b1, 1);

    // Asynchronous reset in the middle of a fill.
    imemREN = 1'b1;
    imemaddr = 32'h0000_0008;
    repeat (2) @(negedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    check_val("arst_iren", 32'(iREN), 32'd0);
    check_val("arst_ihit", 32'(ihit), 32'd0);
    check_val("arst_imemload", imemload, 32'd0);
    check_val("arst_hit_count", hit_count, 32'd0);
    check_val("arst_miss_count", miss_count, 32'd0);
    check_val("arst_hit_count_sat", 32'(hit_count_s), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    access(32'h0000_0008, 1'b1, 1);
    access(32'h0000_0000, 1'b1, 2);

    imemREN = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("scoreboard_empty", exp_q.size(), 0);
    check_val("fetch_queue_empty", fetch_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_dm_param.md
Name: icache_dm_param

Overview:
- Parametrised direct-mapped instruction cache. Sits between the datapath instruction port and the memory-side instruction channel of the caches block.
- Replaces the single-cycle pass-through with real block storage, multi-word block fill, and a whole-cache flush.
- Adds saturating hit/miss counters for performance analysis.
- Each block is filled one word at a time over the existing iREN/iaddr/iwait/iload handshake.

Parameters:
- SETS, 16, number of cache lines; power of two, ≥2.
- BLKWORDS, 2, 32-bit words per block; power of two, ≥2.
- CNTW, 32, width of hit_count and miss_count.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath instruction byte address; bits [1:0] ignored.
- ihit  out  1  requested word is valid this cycle.
- imemload  out  32  requested instruction word.
- flush  in  1  invalidate all lines, abort any fill.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word byte address.
- iwait  in  1  memory not ready; a word transfers on a cycle with iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNTW  saturating count of ihit cycles.
- miss_count  out  CNTW  saturating count of misses.

Behaviour:
- Address split:
  - W = log2(BLKWORDS), I = log2(SETS).
  - Word offset = [2+W-1:2].
  - Index = [2+W+I-1:2+W].
  - Tag = [31:2+W+I].
- Storage per line: valid bit, tag, BLKWORDS data words. All are flops.
- Reset (nRST=0, asynchronous) and flush both clear every valid bit.
- Reset additionally:
  - zeros the data and tag arrays;
  - forces state IDLE, iREN=0, iaddr=0;
  - zeros both counters.
- Outputs while in reset: ihit=0, imemload=0.
- State IDLE:
  - ihit = imemREN & valid[index] & (tag[index]==addr tag), combinational, zero-latency.
  - imemload = data[index][offset] combinationally, in all states.
  - If imemREN and not hit and not flush: latch tag and index, clear the fill word counter, go to FILL, and increment miss_count.
- State FILL:
  - iREN=1, ihit=0.
  - iaddr = {latched tag, latched index, fill counter, 2'b00}.
  - On each cycle with iwait=0: write iload into data[latched index][counter] and increment the counter.
  - On the transfer of word BLKWORDS-1: set valid and tag for the line, then go to IDLE on the next edge.
  - The datapath sees ihit in the cycle after the last transfer.
  - Changes to imemREN or imemaddr during FILL are ignored; the fill always completes against the latched address.
- Miss latency: BLKWORDS memory transfers + 1 cycle.
- Flush (sampled at the clock edge, highest priority after reset):
  - clears all valid bits;
  - in FILL, aborts to IDLE, so iREN=0 in the next cycle and the partial line is not validated;
  - in IDLE, no miss is started that cycle, and ihit is forced to 0 while flush=1.
- Counters:
  - hit_count increments on every cycle with ihit=1. A stalled datapath holding the address counts repeatedly, which is intended.
  - Both counters saturate at all-ones and never wrap.
  - Counters are cleared only by nRST, not by flush.
- Conflict: a miss to an occupied index overwrites the line (no replacement choice, direct-mapped).

Test Plan:
- Bench configuration: SETS=16, BLKWORDS=2, memory model with 2 wait cycles per word.
- After reset, imemREN=1, imemaddr=0x00000000 -> FILL entered; iaddr=0x0 then 0x4; iREN high 6 cycles; ihit=1 on the 7th cycle with imemload=mem[0x0]; miss_count=1.
- Next, imemaddr=0x00000004 -> ihit=1 same cycle, imemload=mem[0x4], hit_count increments by 1 per cycle held.
- imemaddr=0x00000080 (index 0, tag 1) -> miss and refill via iaddr 0x80, 0x84; a following access to 0x0 misses again; miss_count=3.
- flush=1 during the second-word wait of a fill -> iREN=0 next cycle; re-access to the same address misses and refills from word 0.
- CNTW=4, hold a hitting address for 20 cycles -> hit_count=15, no wrap.
- Drive nRST low mid-fill, asynchronously between edges -> iREN=0, ihit=0, counters 0 immediately; after release, the first access misses.
